// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the job-assignment cost server and engine.
package jam_pkg;

    localparam int COST_W     = 7;
    localparam int IDX_W      = 3;
    localparam int MIN_COST_W = 10;
    localparam int MATCH_W    = 4;
    localparam int TBL_DEPTH  = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } jam_state_e;

endpackage

// File: rtl/jam_cost_mem.sv
// Cost table storage: register array with a synchronous write port and an asynchronous read port.
module jam_cost_mem #(
    parameter int COST_W = 7,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COST_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COST_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents are deliberately left unreset; the load sequence defines them.
    logic [COST_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // The engine samples Cost one cycle after presenting W/J, so the read must be combinational.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/jam_cost_server.sv
// Cost-table responder for the assignment engine: loads the 8x8 table, serves lookups, captures the result.
// Optional lookup statistics are enabled with the JAM_LOOKUP_STATS_EN macro.
module jam_cost_server #(
    parameter int COST_W    = jam_pkg::COST_W,
    parameter int IDX_W     = jam_pkg::IDX_W,
    parameter int LKP_CNT_W = 20
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [COST_W-1:0]              ld_data,
    input  logic                           reload,
    input  logic [IDX_W-1:0]               W,
    input  logic [IDX_W-1:0]               J,
    output logic [COST_W-1:0]              Cost,
    input  logic                           Valid,
    input  logic [jam_pkg::MIN_COST_W-1:0] MinCost,
    input  logic [jam_pkg::MATCH_W-1:0]    MatchCount,
    output logic                           tbl_loaded,
    output logic                           res_valid,
    output logic [jam_pkg::MIN_COST_W-1:0] res_min_cost,
    output logic [jam_pkg::MATCH_W-1:0]    res_match_count,
    output logic [LKP_CNT_W-1:0]           lkp_count
);

    import jam_pkg::*;

    localparam int ADDR_W = 2 * IDX_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    jam_state_e               state_reg;
    logic [ADDR_W-1:0]        ptr_reg;
    logic                     ld_ready_reg;
    logic                     tbl_loaded_reg;
    logic                     res_valid_reg;
    logic [MIN_COST_W-1:0]    res_min_cost_reg;
    logic [MATCH_W-1:0]       res_match_count_reg;
    logic                     valid_d_reg;

    logic                     wr_en;
    logic                     valid_rise;
    logic [ADDR_W-1:0]        rd_addr;
    logic [COST_W-1:0]        rd_data;

    assign rd_addr    = {W, J};
    // A reload in the same cycle as a handshake drops the word.
    assign wr_en      = (state_reg == LOAD) && ld_valid && ld_ready_reg && !reload;
    assign valid_rise = (state_reg == SERVE) && Valid && !valid_d_reg;

    jam_cost_mem #(
        .COST_W (COST_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (ptr_reg),
        .wr_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg           <= LOAD;
            ptr_reg             <= '0;
            ld_ready_reg        <= 1'b1;
            tbl_loaded_reg      <= 1'b0;
            res_valid_reg       <= 1'b0;
            res_min_cost_reg    <= '0;
            res_match_count_reg <= '0;
            valid_d_reg         <= 1'b0;
        end else if (reload) begin
            // Captured values are kept; only the valid flag is dropped.
            state_reg      <= LOAD;
            ptr_reg        <= '0;
            ld_ready_reg   <= 1'b1;
            tbl_loaded_reg <= 1'b0;
            res_valid_reg  <= 1'b0;
            valid_d_reg    <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    // Held low so a Valid already high on entry to SERVE reads as a rise.
                    valid_d_reg <= 1'b0;
                    if (wr_en) begin
                        if (ptr_reg == LAST_ADDR) begin
                            state_reg      <= SERVE;
                            ld_ready_reg   <= 1'b0;
                            tbl_loaded_reg <= 1'b1;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    valid_d_reg <= Valid;
                    if (valid_rise) begin
                        res_min_cost_reg    <= MinCost;
                        res_match_count_reg <= MatchCount;
                        res_valid_reg       <= 1'b1;
                        state_reg           <= DONE;
                    end
                end
                DONE: begin
                    valid_d_reg <= Valid;
                end
                default: begin
                    state_reg    <= LOAD;
                    ptr_reg      <= '0;
                    ld_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ld_ready        = ld_ready_reg;
    assign tbl_loaded      = tbl_loaded_reg;
    assign res_valid       = res_valid_reg;
    assign res_min_cost    = res_min_cost_reg;
    assign res_match_count = res_match_count_reg;
    assign Cost            = (state_reg == SERVE || state_reg == DONE) ? rd_data : '0;

`ifdef JAM_LOOKUP_STATS_EN
    logic [ADDR_W-1:0]    prev_idx_reg;
    logic [LKP_CNT_W-1:0] lkp_count_reg;

    // Counts index changes while serving; saturates, and freezes once the result is captured.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_idx_reg  <= '0;
            lkp_count_reg <= '0;
        end else begin
            prev_idx_reg <= rd_addr;
            if (reload) begin
                lkp_count_reg <= '0;
            end else if (state_reg == SERVE && rd_addr != prev_idx_reg && lkp_count_reg != '1) begin
                lkp_count_reg <= lkp_count_reg + 1'b1;
            end
        end
    end

    assign lkp_count = lkp_count_reg;
`else
    assign lkp_count = '0;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: table loads, lookups, result capture, reload and reset.
module tb_jam_cost_server;

    import jam_pkg::*;

    localparam int LKP_CNT_W = 20;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [COST_W-1:0]     ld_data;
    logic                  reload;
    logic [IDX_W-1:0]      W;
    logic [IDX_W-1:0]      J;
    logic [COST_W-1:0]     Cost;
    logic                  Valid;
    logic [MIN_COST_W-1:0] MinCost;
    logic [MATCH_W-1:0]    MatchCount;
    logic                  tbl_loaded;
    logic                  res_valid;
    logic [MIN_COST_W-1:0] res_min_cost;
    logic [MATCH_W-1:0]    res_match_count;
    logic [LKP_CNT_W-1:0]  lkp_count;

    int                    tests_run    = 0;
    int                    tests_failed = 0;
    int                    exp_q[$];
    logic [COST_W-1:0]     model [TBL_DEPTH];
    int                    accepted;
    logic [LKP_CNT_W-1:0]  cnt_before;

    jam_cost_server #(
        .COST_W    (COST_W),
        .IDX_W     (IDX_W),
        .LKP_CNT_W (LKP_CNT_W)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_data         (ld_data),
        .reload          (reload),
        .W               (W),
        .J               (J),
        .Cost            (Cost),
        .Valid           (Valid),
        .MinCost         (MinCost),
        .MatchCount      (MatchCount),
        .tbl_loaded      (tbl_loaded),
        .res_valid       (res_valid),
        .res_min_cost    (res_min_cost),
        .res_match_count (res_match_count),
        .lkp_count       (lkp_count)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] %s ok: %0d", tag, got);
        end
    endtask

    // Drives words at the falling edge; a word counts as accepted when ld_ready is high there.
    task automatic load_words(input int n, input bit toggle, input int base);
        int cyc = 0;
        accepted = 0;
        while (accepted < n && cyc < 400) begin
            @(negedge CLK);
            ld_valid = !toggle || (cyc % 2 == 0);
            ld_data  = COST_W'(accepted + base);
            if (ld_valid && ld_ready) begin
                model[accepted] = ld_data;
                accepted++;
            end
            cyc++;
        end
    endtask

    task automatic lookup(input int w, input int j, input int exp);
        @(negedge CLK);
        W = IDX_W'(w);
        J = IDX_W'(j);
        exp_q.push_back(exp);
        #1;
        check_val($sformatf("cost_%0d_%0d", w, j), 32'(Cost), exp_q.pop_front());
    endtask

    task automatic verify_table();
        for (int a = 0; a < TBL_DEPTH; a++) begin
            lookup(a >> IDX_W, a % (1 << IDX_W), int'(model[a]));
        end
    endtask

    task automatic pulse_reload();
        @(negedge CLK);
        reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; ld_valid = 1'b0; ld_data = '0; reload = 1'b0;
        W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0;
        repeat (3) @(negedge CLK);
        check_val("rst_ld_ready", 32'(ld_ready), 1);
        check_val("rst_tbl_loaded", 32'(tbl_loaded), 0);
        check_val("rst_res_valid", 32'(res_valid), 0);
        check_val("rst_min_cost", 32'(res_min_cost), 0);
        check_val("rst_match", 32'(res_match_count), 0);
        check_val("rst_lkp_count", 32'(lkp_count), 0);
        check_val("rst_cost", 32'(Cost), 0);
        RST = 1'b0;

        // Back-to-back load of k+1
        load_words(TBL_DEPTH, 1'b0, 1);
        check_val("load_a_count", accepted, TBL_DEPTH);
        @(negedge CLK);
        ld_valid = 1'b0;
        check_val("load_a_ready", 32'(ld_ready), 0);
        check_val("load_a_loaded", 32'(tbl_loaded), 1);
        lookup(3, 5, 30);
        lookup(7, 7, 64);
        verify_table();

        // Result capture and hold
        @(negedge CLK);
        MinCost = 10'd123; MatchCount = 4'd2; Valid = 1'b1;
        @(negedge CLK);
        check_val("cap_valid", 32'(res_valid), 1);
        check_val("cap_min_cost", 32'(res_min_cost), 123);
        check_val("cap_match", 32'(res_match_count), 2);
        MinCost = 10'd456; MatchCount = 4'd5; Valid = 1'b0;
        @(negedge CLK);
        Valid = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("hold_min_cost", 32'(res_min_cost), 123);
        check_val("hold_match", 32'(res_match_count), 2);
        lookup(7, 7, 64);
        Valid = 1'b0;

        // Reload from DONE
        pulse_reload();
        check_val("rl_ld_ready", 32'(ld_ready), 1);
        check_val("rl_tbl_loaded", 32'(tbl_loaded), 0);
        check_val("rl_res_valid", 32'(res_valid), 0);
        check_val("rl_cost_zero", 32'(Cost), 0);
        check_val("rl_min_cost_held", 32'(res_min_cost), 123);
        check_val("rl_lkp_count", 32'(lkp_count), 0);

        // Load with ld_valid toggling; extra words after completion must be ignored
        load_words(TBL_DEPTH, 1'b1, 5);
        check_val("load_b_count", accepted, TBL_DEPTH);
        @(negedge CLK);
        check_val("load_b_ready", 32'(ld_ready), 0);
        check_val("load_b_loaded", 32'(tbl_loaded), 1);
        ld_valid = 1'b1;
        ld_data  = 7'h7f;
        repeat (3) @(negedge CLK);
        ld_valid = 1'b0;
        cnt_before = lkp_count;
        verify_table();
        check_val("lkp_nondecreasing", 32'(lkp_count >= cnt_before), 1);
`ifdef JAM_LOOKUP_STATS_EN
        check_val("lkp_nonzero", 32'(lkp_count != '0), 1);
`else
        check_val("lkp_zero", 32'(lkp_count), 0);
`endif

        // Reload coinciding with a Valid rise: no capture
        @(negedge CLK);
        Valid = 1'b1; MinCost = 10'd99; MatchCount = 4'd9; reload = 1'b1;
        @(negedge CLK);
        reload = 1'b0;
        check_val("rlv_res_valid", 32'(res_valid), 0);
        check_val("rlv_min_cost", 32'(res_min_cost), 123);
        check_val("rlv_ld_ready", 32'(ld_ready), 1);
        Valid = 1'b0;

        // Reload coinciding with a load handshake drops the word
        @(negedge CLK);
        ld_valid = 1'b1; ld_data = 7'h55; reload = 1'b1;
        @(negedge CLK);
        ld_valid = 1'b0; reload = 1'b0;

        // Valid held high through the load is captured on entry to SERVE
        Valid = 1'b1; MinCost = 10'd77; MatchCount = 4'd3;
        load_words(TBL_DEPTH, 1'b0, 9);
        check_val("load_c_count", accepted, TBL_DEPTH);
        @(negedge CLK);
        ld_valid = 1'b0;
        check_val("load_c_loaded", 32'(tbl_loaded), 1);
        @(negedge CLK);
        check_val("entry_cap_valid", 32'(res_valid), 1);
        check_val("entry_cap_min", 32'(res_min_cost), 77);
        check_val("entry_cap_match", 32'(res_match_count), 3);
        verify_table();
        Valid = 1'b0;

        // Asynchronous reset after 20 load words
        pulse_reload();
        load_words(20, 1'b0, 40);
        @(negedge CLK);
        ld_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check_val("mrst_ld_ready", 32'(ld_ready), 1);
        check_val("mrst_tbl_loaded", 32'(tbl_loaded), 0);
        check_val("mrst_res_valid", 32'(res_valid), 0);
        check_val("mrst_min_cost", 32'(res_min_cost), 0);
        check_val("mrst_match", 32'(res_match_count), 0);
        check_val("mrst_lkp_count", 32'(lkp_count), 0);
        check_val("mrst_cost", 32'(Cost), 0);
        @(negedge CLK);
        RST = 1'b0;
        load_words(TBL_DEPTH, 1'b0, 20);
        check_val("load_d_count", accepted, TBL_DEPTH);
        @(negedge CLK);
        ld_valid = 1'b0;
        check_val("load_d_loaded", 32'(tbl_loaded), 1);
        verify_table();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
